// File: rtl/iq_fir_pkg.sv
// iq_fir_pkg: shared FSM encoding, default coefficient bank and width helpers for iq_fir_folded
package iq_fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DONE} fsm_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
    return data_w + 1 + coef_w + $clog2(ntaps / 2);
  endfunction
  function automatic int coef_default(input int ntaps, input int idx);
    return ntaps != 10 ? 0 : idx < 2 ? -2 : idx == 2 ? 1 : idx == 3 ? 6 : idx == 4 ? 11 : 0;
  endfunction
endpackage

// File: rtl/iq_fir_folded_sym_tap_line.sv
// sym_tap_line: NTAPS-deep sample delay line (clk, resetn, shift_en, din) returning psum = x[k] + x[NTAPS-1-k]
module sym_tap_line import iq_fir_pkg::*; #(
  parameter int DATA_W = 5,
  parameter int NTAPS = 10,
  localparam int KW = idx_w(NTAPS / 2)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] din,
  input  logic        [KW-1:0]     k,
  output logic signed [DATA_W:0]   psum
);
  localparam int IW = idx_w(NTAPS);
  logic signed [DATA_W-1:0] x [NTAPS];
  logic [IW-1:0] ka, kb;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)
      for (int i = 0; i < NTAPS; i++) x[i] <= '0;
    else if (shift_en) begin
      x[0] <= din;
      for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
    end
  always_comb begin
    ka = IW'(k);
    kb = IW'(NTAPS - 1) - ka;
    psum = (DATA_W+1)'(x[ka]) + (DATA_W+1)'(x[kb]);
  end
endmodule

// File: rtl/iq_fir_folded.sv
// iq_fir_folded: shared folded symmetric FIR over I/Q (in_valid/in_ready/in_i/in_q in; coef_we/addr/data/ack; out_valid/out_i/out_q/sat_flag out)
module iq_fir_folded import iq_fir_pkg::*; #(
  parameter int DATA_W = 5,
  parameter int COEF_W = 6,
  parameter int NTAPS = 10,
  parameter int NCH = 2,
  parameter int OUT_W = 5,
  parameter int SHIFT = 8,
  localparam int NH = NTAPS / 2,
  localparam int KW = idx_w(NH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic                     coef_we,
  input  logic        [KW-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_ack,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_i,
  output logic signed [OUT_W-1:0]  out_q,
  output logic                     sat_flag
);
  localparam int PW = DATA_W + 1 + COEF_W;
  localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);
  localparam int RSH = SHIFT > 0 ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(SHIFT > 0 ? 1 << RSH : 0);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;
  fsm_t state, state_n;
  logic [KW-1:0] k;
  logic ch, take, coef_ok, last, sat_i, sat_q;
  logic signed [COEF_W-1:0] coef [NH];
  logic signed [DATA_W:0] ps_i, ps_q, ps;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_n, hold_i;
  logic signed [ACC_W:0] r_i, r_q;
  function automatic logic signed [ACC_W:0] rnd(input logic signed [ACC_W-1:0] a);
    return ((ACC_W+1)'(a) + RND) >>> SHIFT;
  endfunction
  function automatic logic signed [OUT_W-1:0] clip(input logic signed [ACC_W:0] r);
    return r > MAXV ? MAXV[OUT_W-1:0] : r < MINV ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
  endfunction
  sym_tap_line #(.DATA_W(DATA_W), .NTAPS(NTAPS)) line_i (
    .clk(clk), .resetn(resetn), .shift_en(take), .din(in_i), .k(k), .psum(ps_i)
  );
  sym_tap_line #(.DATA_W(DATA_W), .NTAPS(NTAPS)) line_q (
    .clk(clk), .resetn(resetn), .shift_en(take), .din(in_q), .k(k), .psum(ps_q)
  );
  always_comb begin
    in_ready = state == IDLE;
    take = in_ready && in_valid;
    coef_ok = in_ready && coef_we && 32'(coef_addr) < NH;
    last = 32'(k) == NH - 1;
    ps = ch ? ps_q : ps_i;
    prod = PW'(ps) * PW'(coef[k]);
    acc_n = k == '0 ? ACC_W'(prod) : acc + ACC_W'(prod);
    state_n = state == IDLE ? (in_valid ? MAC : IDLE) :
              state == MAC ? (ch == 1'(NCH - 1) && last ? DONE : MAC) : IDLE;
    r_i = rnd(hold_i);
    r_q = rnd(acc);
    sat_i = r_i > MAXV || r_i < MINV;
    sat_q = r_q > MAXV || r_q < MINV;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      k <= '0;
      ch <= 1'b0;
      acc <= '0;
      hold_i <= '0;
      coef_ack <= 1'b0;
      out_valid <= 1'b0;
      out_i <= '0;
      out_q <= '0;
      sat_flag <= 1'b0;
      for (int i = 0; i < NH; i++) coef[i] <= COEF_W'(coef_default(NTAPS, i));
    end else begin
      coef_ack <= coef_ok;
      out_valid <= state == DONE;
      if (coef_ok) coef[coef_addr] <= coef_data;
      if (state == MAC) begin
        acc <= acc_n;
        k <= last ? '0 : k + 1'b1;
        ch <= last ? ~ch : ch;
        if (!ch && last) hold_i <= acc_n;
      end
      if (state == DONE) begin
        out_i <= clip(r_i);
        out_q <= clip(r_q);
        sat_flag <= sat_i || sat_q;
      end
    end
endmodule

// File: tb/tb_iq_fir_folded.sv
// tb_iq_fir_folded: scoreboard bench for iq_fir_folded (default instance plus SHIFT=0/OUT_W=12 impulse instance)
module tb_iq_fir_folded;
  typedef struct {int i; int q; bit s;} exp_t;
  logic clk = 0, resetn = 0;
  logic in_valid0 = 0, in_valid1 = 0, coef_we = 0, coef_we1 = 0;
  logic signed [4:0] in_i0 = 0, in_q0 = 0, in_i1 = 0, in_q1 = 0;
  logic [2:0] coef_addr = 0, coef_addr1 = 0;
  logic signed [5:0] coef_data = 0, coef_data1 = 0;
  logic in_ready0, in_ready1, coef_ack0, coef_ack1, out_valid0, out_valid1, sat0, sat1;
  logic signed [4:0] out_i0, out_q0;
  logic signed [11:0] out_i1, out_q1;
  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int dc_i[10] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
  int dc_q[10] = '{0, 0, 0, 0, -1, -2, -2, -2, -2, -2};
  int st_i[10] = '{2, 4, 5, 7, 9, 11, 13, 15, 15, 15};
  int st_q[10] = '{-2, -4, -6, -8, -10, -12, -14, -15, -16, -16};
  int imp[12] = '{-2, -2, 1, 6, 11, 11, 6, 1, -2, -2, 0, 0};
  always #5 clk = ~clk;
  iq_fir_folded dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid0), .in_ready(in_ready0), .in_i(in_i0), .in_q(in_q0),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ack(coef_ack0),
    .out_valid(out_valid0), .out_i(out_i0), .out_q(out_q0), .sat_flag(sat0)
  );
  iq_fir_folded #(.OUT_W(12), .SHIFT(0)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid1), .in_ready(in_ready1), .in_i(in_i1), .in_q(in_q1),
    .coef_we(coef_we1), .coef_addr(coef_addr1), .coef_data(coef_data1), .coef_ack(coef_ack1),
    .out_valid(out_valid1), .out_i(out_i1), .out_q(out_q1), .sat_flag(sat1)
  );
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (out_valid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0 output: unexpected out_valid with i=%0d q=%0d", out_i0, out_q0);
      end else begin
        e = q0.pop_front();
        if (int'(out_i0) != e.i || int'(out_q0) != e.q || sat0 != e.s) begin
          errors++;
          $display("FAIL dut0 output: got i=%0d q=%0d sat=%0b, want i=%0d q=%0d sat=%0b",
                   out_i0, out_q0, sat0, e.i, e.q, e.s);
        end
      end
    end
  end
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (out_valid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1 output: unexpected out_valid with i=%0d q=%0d", out_i1, out_q1);
      end else begin
        e = q1.pop_front();
        if (int'(out_i1) != e.i || int'(out_q1) != e.q || sat1 != e.s) begin
          errors++;
          $display("FAIL dut1 output: got i=%0d q=%0d sat=%0b, want i=%0d q=%0d sat=%0b",
                   out_i1, out_q1, sat1, e.i, e.q, e.s);
        end
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    #1;
    chk("reset out_valid0", out_valid0, 0);
    chk("reset out_i0", out_i0, 0);
    chk("reset out_q0", out_q0, 0);
    chk("reset sat0", sat0, 0);
    chk("reset out_i1", out_i1, 0);
    chk("reset coef_ack0", coef_ack0, 0);
    chk("reset in_ready0", in_ready0, 1);
    @(negedge clk);
    resetn = 1;
  endtask
  task automatic drain();
    int g = 0;
    while ((q0.size() + q1.size()) != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain pending outputs", q0.size() + q1.size(), 0);
  endtask
  task automatic impulse1();
    int n = 0, g = 0;
    while (n < 12 && g < 400) begin
      @(negedge clk);
      g++;
      in_valid1 = 1;
      in_i1 = in_ready1 ? 5'(n == 0 ? 1 : 0) : 5'($urandom);
      in_q1 = in_ready1 ? 5'(0) : 5'($urandom);
      if (in_ready1) begin
        q1.push_back(exp_t'{imp[n], 0, 1'b0});
        n++;
      end
    end
    chk("impulse samples accepted", n, 12);
    @(negedge clk);
    in_valid1 = 0;
  endtask
  task automatic stream0(input bit use_sat);
    int n = 0;
    for (int cyc = 0; cyc <= 120; cyc++) begin
      @(negedge clk);
      in_valid0 = n < 10;
      in_i0 = in_ready0 ? 5'(15) : 5'($urandom);
      in_q0 = in_ready0 ? 5'(-16) : 5'($urandom);
      chk("in_ready timing", in_ready0, int'(cyc % 12 == 0));
      chk("out_valid timing", out_valid0, int'(cyc % 12 == 0 && cyc > 0));
      if (in_valid0 && in_ready0) begin
        q0.push_back(use_sat ? exp_t'{st_i[n], st_q[n], n >= 8} : exp_t'{dc_i[n], dc_q[n], 1'b0});
        n++;
      end
    end
    in_valid0 = 0;
  endtask
  task automatic wcoef(input int a, input int d, input int want_ack);
    @(negedge clk);
    coef_we = 1;
    coef_addr = 3'(a);
    coef_data = 6'(d);
    @(negedge clk);
    coef_we = 0;
    chk("coef_ack", coef_ack0, want_ack);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("init out_valid0", out_valid0, 0);
    chk("init out_valid1", out_valid1, 0);
    chk("init out_i0", out_i0, 0);
    chk("init out_q1", out_q1, 0);
    chk("init sat0", sat0, 0);
    chk("init coef_ack0", coef_ack0, 0);
    resetn = 1;
    impulse1();
    drain();
    do_reset();
    stream0(0);
    drain();
    do_reset();
    for (int i = 0; i < 5; i++) wcoef(i, 31, 1);
    stream0(1);
    drain();
    do_reset();
    wcoef(5, 31, 0);
    @(negedge clk);
    chk("in_ready before combined write", in_ready0, 1);
    in_valid0 = 1;
    in_i0 = 5'(15);
    in_q0 = 5'(-16);
    coef_we = 1;
    coef_addr = 3'(0);
    coef_data = 6'(31);
    q0.push_back(exp_t'{2, -2, 1'b0});
    @(negedge clk);
    in_valid0 = 0;
    coef_we = 0;
    chk("coef_ack with sample", coef_ack0, 1);
    repeat (2) @(negedge clk);
    chk("in_ready during MAC", in_ready0, 0);
    coef_we = 1;
    coef_data = 6'(-2);
    @(negedge clk);
    coef_we = 0;
    chk("coef_ack during MAC", coef_ack0, 0);
    drain();
    @(negedge clk);
    chk("in_ready second sample", in_ready0, 1);
    in_valid0 = 1;
    q0.push_back(exp_t'{2, -2, 1'b0});
    @(negedge clk);
    in_valid0 = 0;
    drain();
    do_reset();
    @(negedge clk);
    in_valid1 = 1;
    in_i1 = 5'(1);
    in_q1 = 5'(0);
    q1.push_back(exp_t'{-2, 0, 1'b0});
    @(negedge clk);
    in_valid1 = 0;
    drain();
    chk("out_i1 held", out_i1, -2);
    @(negedge clk);
    chk("in_ready1 before abort", in_ready1, 1);
    in_valid1 = 1;
    in_i1 = 5'(0);
    @(negedge clk);
    in_valid1 = 0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    resetn = 0;
    #1;
    chk("abort out_i1", out_i1, 0);
    chk("abort out_valid1", out_valid1, 0);
    chk("abort sat1", sat1, 0);
    @(negedge clk);
    resetn = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("no out_valid after abort", out_valid1, 0);
    end
    impulse1();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
